// File: rtl/rv32_alu_if.sv
// rv32_alu_if: operand/op request and registered result bus for the RV32I ALU
interface rv32_alu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [3:0]      AluOp;
  logic [XLEN-1:0] S;
  logic            out_valid;
  logic            zero;
  modport master (output in_valid, A, B, AluOp, input S, out_valid, zero);
  modport slave  (input in_valid, A, B, AluOp, output S, out_valid, zero);
endinterface

// File: rtl/rv32_alu.sv
// rv32_alu: RV32I integer ALU with a one-cycle registered result, valid strobe and zero flag
module rv32_alu #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  rv32_alu_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sra;
  logic [XLEN-1:0] f;
  assign shamt = bus.B[SW-1:0];
  // kept separate so the arithmetic shift is not made unsigned by the select chain
  assign sra = $signed(bus.A) >>> shamt;
  always_comb begin
    f = bus.AluOp == OP_ADD  ? bus.A + bus.B :
        bus.AluOp == OP_SUB  ? bus.A - bus.B :
        bus.AluOp == OP_SLL  ? bus.A << shamt :
        bus.AluOp == OP_SLT  ? {{(XLEN-1){1'b0}}, $signed(bus.A) < $signed(bus.B)} :
        bus.AluOp == OP_SLTU ? {{(XLEN-1){1'b0}}, bus.A < bus.B} :
        bus.AluOp == OP_XOR  ? bus.A ^ bus.B :
        bus.AluOp == OP_SRL  ? bus.A >> shamt :
        bus.AluOp == OP_SRA  ? sra :
        bus.AluOp == OP_OR   ? bus.A | bus.B :
        bus.AluOp == OP_AND  ? bus.A & bus.B :
        '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.S         <= '0;
      bus.out_valid <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.S    <= f;
        bus.zero <= f == '0;
      end
    end
  end
endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: directed table, hold/stream/reset sequences and random ops against a reference model
module tb_rv32_alu;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] s;
    logic        z;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rv32_alu_if #(.XLEN(32)) bus();
  rv32_alu #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_s;
  logic        exp_z;
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int unsigned sh = b % 32;
    logic [63:0] wide;
    case (op)
      4'b0000: ref_alu = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'b1000: ref_alu = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      4'b0001: begin wide = 64'(a) * (64'd1 << sh); ref_alu = wide[31:0]; end
      4'b0010: ref_alu = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b0011: ref_alu = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      4'b0100: ref_alu = a ^ b;
      4'b0101: ref_alu = 32'(64'(a) / (64'd1 << sh));
      4'b1101: ref_alu = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'b0110: ref_alu = a | b;
      4'b0111: ref_alu = a & b;
      default: ref_alu = 32'd0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.AluOp = op;
    @(posedge clk);
    #1;
  endtask
  task automatic check_out(input string name, input logic ov);
    chk({name, ".S"}, bus.S, exp_s);
    chk({name, ".zero"}, 32'(bus.zero), 32'(exp_z));
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
  endtask
  vec_t tbl[$];
  initial begin
    tbl.push_back('{32'd5, 32'd3, 4'b0000, 32'd8, 1'b0});
    tbl.push_back('{32'd8, 32'd3, 4'b1000, 32'd5, 1'b0});
    tbl.push_back('{32'd4, 32'd2, 4'b0001, 32'd16, 1'b0});
    tbl.push_back('{-32'sd5, 32'd3, 4'b0010, 32'd1, 1'b0});
    tbl.push_back('{32'd5, 32'd3, 4'b0011, 32'd0, 1'b1});
    tbl.push_back('{-32'sd5, 32'd3, 4'b0011, 32'd0, 1'b1});
    tbl.push_back('{32'd5, 32'd3, 4'b0100, 32'd6, 1'b0});
    tbl.push_back('{32'd5, 32'd3, 4'b0110, 32'd7, 1'b0});
    tbl.push_back('{32'd5, 32'd3, 4'b0111, 32'd1, 1'b0});
    tbl.push_back('{32'd8, 32'd2, 4'b0101, 32'd2, 1'b0});
    tbl.push_back('{-32'sd8, 32'd2, 4'b1101, 32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{-32'sd8, 32'd2, 4'b0101, 32'h3FFF_FFFE, 1'b0});
    tbl.push_back('{32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 1'b0});
    tbl.push_back('{32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{32'd1, 32'h21, 4'b0001, 32'd2, 1'b0});
    tbl.push_back('{32'h1234_5678, 32'd0, 4'b0101, 32'h1234_5678, 1'b0});
    tbl.push_back('{32'h8000_0000, 32'd0, 4'b0010, 32'd1, 1'b0});
    tbl.push_back('{32'h8000_0000, 32'd0, 4'b0011, 32'd0, 1'b1});
    tbl.push_back('{32'h8000_0000, 32'd31, 4'b1101, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{32'hDEAD_BEEF, 32'h1234, 4'b1111, 32'd0, 1'b1});
    tbl.push_back('{32'hDEAD_BEEF, 32'h1234, 4'b1010, 32'd0, 1'b1});
    bus.in_valid = 1'b1;
    bus.A = 32'd5;
    bus.B = 32'd3;
    bus.AluOp = 4'b0000;
    rst_n = 1'b0;
    drive(1'b1, 32'd5, 32'd3, 4'b0000);
    drive(1'b1, 32'd5, 32'd3, 4'b0000);
    exp_s = 32'd0;
    exp_z = 1'b0;
    check_out("reset", 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 32'd5, 32'd3, 4'b0000);
    exp_s = 32'd8;
    check_out("first_after_reset", 1'b1);
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].op);
      exp_s = tbl[i].s;
      exp_z = tbl[i].z;
      check_out($sformatf("vec%0d", i), 1'b1);
      chk($sformatf("model%0d", i), ref_alu(tbl[i].a, tbl[i].b, tbl[i].op), tbl[i].s);
    end
    drive(1'b1, 32'd100, 32'd23, 4'b1000);
    exp_s = 32'd77;
    exp_z = 1'b0;
    check_out("pre_hold", 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom, $urandom, 4'b0000);
      check_out($sformatf("hold%0d", i), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      logic [3:0] op = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0100 : (i == 2) ? 4'b1101 : 4'b0011;
      drive(1'b1, a, b, op);
      exp_s = ref_alu(a, b, op);
      exp_z = exp_s == 32'd0;
      check_out($sformatf("stream%0d", i), 1'b1);
    end
    rst_n = 1'b0;
    drive(1'b1, 32'd7, 32'd7, 4'b0000);
    rst_n = 1'b1;
    drive(1'b0, 32'd1, 32'd1, 4'b0000);
    exp_s = 32'd0;
    exp_z = 1'b0;
    check_out("inflight_discard", 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic v = $urandom_range(0, 3) != 0;
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      logic [3:0] op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) b = a;
      drive(v, a, b, op);
      if (v) begin
        exp_s = ref_alu(a, b, op);
        exp_z = exp_s == 32'd0;
      end
      check_out($sformatf("rand%0d", i), v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
